// File: rtl/image_streamer.sv
// Streams a captured image snapshot byte-by-byte over a valid/ready port,
// optionally followed by an XOR checksum byte, with abort and one-cycle done pulse.
module image_streamer #(
  parameter int unsigned IMG_BYTES   = 113,
  parameter bit          CHECKSUM_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [903:0] img_in,
  input  logic         start,
  input  logic         abort,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_last,
  output logic [6:0]   tx_index,
  output logic         busy,
  output logic         done
);

  localparam logic [6:0] LastIdx = 7'(IMG_BYTES - 1);
  localparam logic [6:0] CkIdx   = 7'(IMG_BYTES);

  typedef enum logic [1:0] {StIdle, StStream, StCksum, StDone} state_e;

  state_e       state_q, state_d;
  logic [903:0] snap_q;
  logic [7:0]   cksum_q, cksum_d;
  logic [7:0]   data_q, data_d;
  logic [6:0]   idx_q, idx_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic       capture;
  logic       fire;
  logic [6:0] idx_nx;
  logic [7:0] snap_byte;

  assign capture   = (state_q == StIdle) && start && !abort;
  assign fire      = valid_q && tx_ready;
  assign idx_nx    = idx_q + 7'd1;
  // Only consulted while idx_q < LastIdx, so the select stays inside the snapshot.
  assign snap_byte = snap_q[{idx_nx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cksum_q <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cksum_q <= cksum_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Snapshot needs no reset; it is always rewritten before use.
  always_ff @(posedge clk) begin
    if (capture) snap_q <= img_in;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (capture) state_d = StStream;
      StStream: begin
        if (abort) state_d = StIdle;
        else if (fire && idx_q == LastIdx) state_d = CHECKSUM_EN ? StCksum : StDone;
      end
      StCksum:  begin
        if (abort) state_d = StIdle;
        else if (fire) state_d = StDone;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    idx_d   = idx_q;
    cksum_d = cksum_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (capture) begin
          data_d  = img_in[7:0];
          idx_d   = '0;
          cksum_d = '0;
          valid_d = 1'b1;
          last_d  = !CHECKSUM_EN && (LastIdx == 7'd0);
          busy_d  = 1'b1;
        end
      end
      StStream: begin
        if (abort) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (fire) begin
          cksum_d = cksum_q ^ data_q;
          if (idx_q == LastIdx) begin
            if (CHECKSUM_EN) begin
              data_d = cksum_q ^ data_q;
              idx_d  = CkIdx;
              last_d = 1'b1;
            end else begin
              valid_d = 1'b0;
              last_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            data_d = snap_byte;
            idx_d  = idx_nx;
            last_d = !CHECKSUM_EN && (idx_nx == LastIdx);
          end
        end
      end
      StCksum: begin
        if (abort || fire) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = !abort;
        end
      end
      StDone: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx_data  = data_q;
  assign tx_valid = valid_q;
  assign tx_last  = last_q;
  assign tx_index = idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_image_streamer.sv
// Scoreboard bench for image_streamer: stimulus queues expected bytes, a negedge
// monitor pops and compares every transfer and checks stall stability.
module tb_image_streamer;

  typedef struct {
    logic [7:0] d;
    logic [6:0] i;
    logic       l;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [903:0] img_in;
  logic         start, start_nc, abort, tx_ready;
  logic [7:0]   tx_data, tx_data_nc;
  logic         tx_valid, tx_last, busy, done;
  logic         tx_valid_nc, tx_last_nc, busy_nc, done_nc;
  logic [6:0]   tx_index, tx_index_nc;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   xfer_cnt = 0;
  int   done_cnt = 0;
  bit   rnd = 0;
  bit   scr = 0;

  always #5 clk = ~clk;

  image_streamer #(.IMG_BYTES(113), .CHECKSUM_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .img_in(img_in), .start(start), .abort(abort),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .tx_index(tx_index), .busy(busy), .done(done)
  );

  image_streamer #(.IMG_BYTES(113), .CHECKSUM_EN(1'b0)) u_dut_nc (
    .clk(clk), .rst_n(rst_n), .img_in(img_in), .start(start_nc), .abort(abort),
    .tx_data(tx_data_nc), .tx_valid(tx_valid_nc), .tx_ready(tx_ready),
    .tx_last(tx_last_nc), .tx_index(tx_index_nc), .busy(busy_nc), .done(done_nc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_img(input logic [7:0] key);
    for (int i = 0; i < 113; i++) img_in[i*8 +: 8] = 8'(i) ^ key;
  endtask

  task automatic push_bytes(input logic [7:0] key, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = 8'(i) ^ key;
      e.i = 7'(i);
      e.l = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic push_ck(input logic [7:0] ck);
    exp_t e;
    e.d = ck;
    e.i = 7'd113;
    e.l = 1'b1;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd) tx_ready = 1'($urandom_range(0, 1));
    if (scr) for (int i = 0; i < 113; i++) img_in[i*8 +: 8] = 8'($urandom);
  endtask

  task automatic do_start(input logic [7:0] key);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_valid", 32'(tx_valid), 32'd1);
    chk("start_data", 32'(tx_data), 32'(key));
    chk("start_index", 32'(tx_index), 32'd0);
  endtask

  task automatic wait_xfer(input int n);
    bit ok = 0;
    for (int k = 0; k < 3000; k++) begin
      if (xfer_cnt >= n) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) chk("wait_xfer_timeout", 32'(xfer_cnt), 32'(n));
  endtask

  task automatic wait_empty();
    bit ok = 0;
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      chk("wait_empty_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic check_done();
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_valid", 32'(tx_valid), 32'd0);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  // Monitor: a transfer happens at the next rising edge when valid && ready here.
  initial begin
    exp_t    e;
    bit      stall = 0;
    logic [7:0] hd;
    logic [6:0] hi;
    logic       hl;
    forever begin
      @(negedge clk);
      if (rst_n && tx_valid) begin
        if (stall) begin
          chk("stall_data", 32'(tx_data), 32'(hd));
          chk("stall_index", 32'(tx_index), 32'(hi));
          chk("stall_last", 32'(tx_last), 32'(hl));
        end
        if (tx_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_xfer", 32'(tx_index), 32'h7f);
          end else begin
            e = sb.pop_front();
            chk("xfer_data", 32'(tx_data), 32'(e.d));
            chk("xfer_index", 32'(tx_index), 32'(e.i));
            chk("xfer_last", 32'(tx_last), 32'(e.l));
          end
          xfer_cnt++;
          stall = 0;
        end else begin
          stall = 1;
          hd = tx_data;
          hi = tx_index;
          hl = tx_last;
        end
      end else begin
        stall = 0;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    int d0;
    tx_ready = 1'b1;
    start    = 1'b0;
    start_nc = 1'b0;
    abort    = 1'b0;
    set_img(8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_index", 32'(tx_index), 32'd0);
    chk("rst_last", 32'(tx_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Full frame, ready always high: bytes 0..112 then checksum 0x70.
    push_bytes(8'h00, 113);
    push_ck(8'h70);
    xfer_cnt = 0;
    do_start(8'h00);
    chk("busy_stream", 32'(busy), 32'd1);
    wait_empty();
    check_done();
    chk("frame1_xfers", 32'(xfer_cnt), 32'd114);

    // Pseudo-random backpressure.
    rnd = 1;
    push_bytes(8'h00, 113);
    push_ck(8'h70);
    xfer_cnt = 0;
    do_start(8'h00);
    wait_empty();
    rnd = 0;
    tx_ready = 1'b1;
    check_done();
    chk("frame2_xfers", 32'(xfer_cnt), 32'd114);

    // Abort after 50 transfers; byte 50 still transfers on the abort cycle.
    push_bytes(8'h00, 51);
    xfer_cnt = 0;
    d0 = done_cnt;
    do_start(8'h00);
    wait_xfer(50);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(tx_valid), 32'd0);
    chk("abort_last", 32'(tx_last), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (4) tick();
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    chk("abort_xfers", 32'(xfer_cnt), 32'd51);
    chk("abort_sb_empty", 32'(sb.size()), 32'd0);

    push_bytes(8'h00, 113);
    push_ck(8'h70);
    xfer_cnt = 0;
    do_start(8'h00);
    wait_empty();
    check_done();

    // Snapshot isolation plus an ignored restart at transfer 20.
    set_img(8'hA5);
    push_bytes(8'hA5, 113);
    push_ck(8'hD5);
    xfer_cnt = 0;
    do_start(8'hA5);
    scr = 1;
    wait_xfer(20);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_empty();
    scr = 0;
    check_done();
    chk("frame3_xfers", 32'(xfer_cnt), 32'd114);
    chk("done_count", 32'(done_cnt), 32'd4);

    // Build without checksum: tx_last on byte 112, then done.
    set_img(8'h00);
    start_nc = 1'b1;
    tick();
    start_nc = 1'b0;
    for (int i = 0; i < 113; i++) begin
      chk("nc_valid", 32'(tx_valid_nc), 32'd1);
      chk("nc_data", 32'(tx_data_nc), 32'(i));
      chk("nc_index", 32'(tx_index_nc), 32'(i));
      chk("nc_last", 32'(tx_last_nc), 32'(i == 112));
      tick();
    end
    chk("nc_done", 32'(done_nc), 32'd1);
    chk("nc_valid_end", 32'(tx_valid_nc), 32'd0);

    // Asynchronous reset between edges mid-frame.
    push_bytes(8'h00, 113);
    push_ck(8'h70);
    xfer_cnt = 0;
    do_start(8'h00);
    wait_xfer(30);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(tx_valid), 32'd0);
    chk("arst_data", 32'(tx_data), 32'd0);
    chk("arst_index", 32'(tx_index), 32'd0);
    chk("arst_last", 32'(tx_last), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    sb.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_valid", 32'(tx_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    chk("final_done_count", 32'(done_cnt), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
